// File: rtl/fib_mem_responder.sv
// rtl/fib_mem_responder.sv - host job front-end exposing start flag and argument to a core as a 2-word memory
// The core polls word0 for the start pulse, reads word1 for n and writes its result back to end the job.
module fib_mem_responder #(
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 1000,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [DATA_WIDTH-1:0] req_arg,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_result,
  output logic                  rsp_timeout,
  output logic [CNT_WIDTH-1:0]  rsp_cycles,
  input  logic [31:0]           mem_addr_i,
  input  logic                  mem_wen_i,
  input  logic [DATA_WIDTH-1:0] mem_wdata_i,
  output logic [DATA_WIDTH-1:0] mem_rdata_o
);

  localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, START, RUN, DONE} state_t;

  state_t                  state_q;
  logic                    word0_q;
  logic [DATA_WIDTH-1:0]   word1_q;
  logic [CNT_WIDTH-1:0]    cyc_q;
  logic [CNT_WIDTH-1:0]    cyc_d;
  logic [TW-1:0]           tmo_q;
  logic                    rsp_valid_q;
  logic [DATA_WIDTH-1:0]   rsp_result_q;
  logic                    rsp_timeout_q;
  logic [CNT_WIDTH-1:0]    rsp_cycles_q;

  // Latency counter sticks at all-ones rather than wrapping.
  assign cyc_d = (&cyc_q) ? cyc_q : cyc_q + CNT_WIDTH'(1);

  assign mem_rdata_o = (mem_addr_i == 32'd1) ? word1_q : {{(DATA_WIDTH-1){1'b0}}, word0_q};
  assign req_ready   = (state_q == IDLE);
  assign rsp_valid   = rsp_valid_q;
  assign rsp_result  = rsp_result_q;
  assign rsp_timeout = rsp_timeout_q;
  assign rsp_cycles  = rsp_cycles_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      word0_q       <= 1'b0;
      word1_q       <= '0;
      cyc_q         <= '0;
      tmo_q         <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_result_q  <= '0;
      rsp_timeout_q <= 1'b0;
      rsp_cycles_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            word1_q <= req_arg;
            word0_q <= 1'b1;
            cyc_q   <= CNT_WIDTH'(1);
            state_q <= START;
          end
        end
        START: begin
          word0_q <= 1'b0;
          cyc_q   <= cyc_d;
          tmo_q   <= TW'(TIMEOUT);
          if (mem_wen_i) begin
            rsp_result_q  <= mem_wdata_i;
            rsp_timeout_q <= 1'b0;
            rsp_cycles_q  <= cyc_q;
            rsp_valid_q   <= 1'b1;
            state_q       <= DONE;
          end else begin
            state_q <= RUN;
          end
        end
        RUN: begin
          cyc_q <= cyc_d;
          // A write on the final budget cycle still counts as a completion.
          if (mem_wen_i) begin
            rsp_result_q  <= mem_wdata_i;
            rsp_timeout_q <= 1'b0;
            rsp_cycles_q  <= cyc_q;
            rsp_valid_q   <= 1'b1;
            state_q       <= DONE;
          end else if (tmo_q == '0) begin
            rsp_result_q  <= '0;
            rsp_timeout_q <= 1'b1;
            rsp_cycles_q  <= cyc_q;
            rsp_valid_q   <= 1'b1;
            state_q       <= DONE;
          end else begin
            tmo_q <= tmo_q - TW'(1);
          end
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/fib_mem_responder.md
FIB_MEM_RESPONDER -- requirements
Module: fib_mem_responder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: width of argument, result and memory words.
REQ-002 SHALL have parameter TIMEOUT, default 1000: RUN-cycle budget before abort.
REQ-003 SHALL have parameter CNT_WIDTH, default 16: width of the cycle counter.
REQ-004 SHALL have port clk, input, 1: single clock, all state rising-edge.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-006 SHALL have port req_valid, input, 1: host offers a job.
REQ-007 SHALL have port req_ready, output, 1: block accepts a job.
REQ-008 SHALL have port req_arg, input, DATA_WIDTH: job argument n.
REQ-009 SHALL have port rsp_valid, output, 1: result available.
REQ-010 SHALL have port rsp_ready, input, 1: host consumes result.
REQ-011 SHALL have port rsp_result, output, DATA_WIDTH: captured core write data.
REQ-012 SHALL have port rsp_timeout, output, 1: job aborted by timeout.
REQ-013 SHALL have port rsp_cycles, output, CNT_WIDTH: job latency in cycles.
REQ-014 SHALL have port mem_addr_i, input, 32: core read/write address.
REQ-015 SHALL have port mem_wen_i, input, 1: core write strobe.
REQ-016 SHALL have port mem_wdata_i, input, DATA_WIDTH: core write data.
REQ-017 SHALL have port mem_rdata_o, output, DATA_WIDTH: read data to core.

Function
REQ-018 SHALL hold two words: word0 = start flag (0/1, zero-extended), word1 = argument.
REQ-019 SHALL drive mem_rdata_o combinationally: word1 when mem_addr_i==1, else word0.
REQ-020 SHALL implement FSM IDLE, START, RUN, DONE.
REQ-021 IDLE: req_ready=1; on req_valid: word1<=req_arg, word0<=1, cycle counter<=1, go START.
REQ-022 START: exactly one cycle; word0<=0 at exit, timeout counter<=TIMEOUT, go RUN.
REQ-023 START/RUN: mem_wen_i captures mem_wdata_i into rsp_result, rsp_timeout<=0, go DONE; any address accepted.
REQ-024 RUN without mem_wen_i: timeout counter==0 -> rsp_timeout<=1, rsp_result<=0, go DONE; else decrement.
REQ-025 Simultaneous mem_wen_i and timeout counter==0: write wins, rsp_timeout=0.
REQ-026 Cycle counter increments each cycle in START/RUN, saturating at all-ones; value at DONE entry = rsp_cycles.
REQ-027 DONE: rsp_valid=1, rsp_* stable until rsp_ready; then go IDLE.
REQ-028 req_ready SHALL be 0 outside IDLE; a job is never accepted in the DONE handshake cycle.
REQ-029 mem_wen_i in IDLE or DONE SHALL be ignored, with no state change.
REQ-030 word1 SHALL retain the argument until the next accepted job.

Reset
REQ-031 rst SHALL force IDLE asynchronously, with word0=0, word1=0, rsp_valid=0, rsp_result=0, rsp_timeout=0, rsp_cycles=0, and both counters=0.
REQ-032 rst mid-job SHALL abandon the job with no response; req_ready=1 on the first cycle after deassertion.

Verification
REQ-033 Job n=5; core reads addr 1 -> 5; core writes 5 on third RUN cycle -> rsp_valid, rsp_result=5, rsp_timeout=0, rsp_cycles=4.
REQ-034 Job accepted -> mem_rdata_o at addr 0 reads 1 for exactly one cycle (START), then 0.
REQ-035 TIMEOUT=8, core never writes -> after 9 RUN cycles: rsp_timeout=1, rsp_result=0, rsp_cycles=10.
REQ-036 TIMEOUT=8, write on the 9th RUN cycle -> rsp_timeout=0, result captured.
REQ-037 rsp_ready low 5 cycles -> rsp_* held, req_ready=0, stray mem_wen_i ignored; then accept and return to IDLE.
REQ-038 rst pulse mid-RUN -> all outputs at reset values; a following job n=6 completes normally.
